// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light front end.
package traffic_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        PRESENT = 2'd2,
        HOLD    = 2'd3
    } lane_state_t;

    localparam logic [7:0] VEH_CNT_MAX = 8'd255;

    // A lane requests service while a vehicle is present or within its gap hold.
    function automatic logic is_present(input lane_state_t s);
        return (s == PRESENT) || (s == HOLD);
    endfunction

endpackage

// File: rtl/sensor_lane.sv
// One detector lane: synchroniser, debounce/gap-hold FSM, stuck detector,
// saturating vehicle counter and sticky fault flag.
module sensor_lane
    import traffic_pkg::*;
#(
    parameter int unsigned DEB_CYC   = 4,
    parameter int unsigned HOLD_CYC  = 8,
    parameter int unsigned STUCK_CYC = 1000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_raw,
    input  logic       i_cnt_clr,
    input  logic       i_fault_clr,
    output logic       o_car,
    output logic [7:0] o_veh_cnt,
    output logic       o_fault
);

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] STUCK_LAST = CNT_W'(STUCK_CYC - 1);

    logic             r_s1;
    logic             r_s2;
    lane_state_t      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_stuck;
    logic             r_fault;
    logic [7:0]       r_veh;
    logic             r_car;

    lane_state_t      w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_stuck_nxt;
    logic             w_fault_nxt;
    logic [7:0]       w_veh_nxt;
    logic             w_car_nxt;
    logic             w_inc;

    // Two-flop synchroniser for the asynchronous detector input.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= i_raw;
            r_s2 <= r_s1;
        end
    end

    // Lane state, counters, fault flag and registered presence output.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_stuck <= '0;
            r_fault <= 1'b0;
            r_veh   <= '0;
            r_car   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_stuck <= w_stuck_nxt;
            r_fault <= w_fault_nxt;
            r_veh   <= w_veh_nxt;
            r_car   <= w_car_nxt;
        end
    end

    // Next-state logic: debounce on arrival, gap hold on departure, stuck watch.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_stuck_nxt = r_stuck;
        w_fault_nxt = r_fault;
        w_inc       = 1'b0;

        case (r_state)
            IDLE: begin
                if (r_s2) begin
                    w_state_nxt = ARM;
                    w_cnt_nxt   = ONE;
                end
            end
            ARM: begin
                if (!r_s2) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_nxt = PRESENT;
                    w_cnt_nxt   = '0;
                    w_stuck_nxt = '0;
                    w_inc       = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + ONE;
                end
            end
            PRESENT: begin
                if (!r_s2) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = ONE;
                end else if (r_stuck == STUCK_LAST) begin
                    w_fault_nxt = 1'b1;
                end else begin
                    w_stuck_nxt = r_stuck + ONE;
                end
            end
            HOLD: begin
                // Return within the gap is the same vehicle: no count increment.
                if (r_s2) begin
                    w_state_nxt = PRESENT;
                    w_cnt_nxt   = '0;
                    w_stuck_nxt = '0;
                end else if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + ONE;
                end
            end
        endcase

        // Maintenance clear takes priority over a fault being raised this edge.
        if (i_fault_clr) begin
            w_stuck_nxt = '0;
            w_fault_nxt = 1'b0;
        end

        if (i_cnt_clr) begin
            w_veh_nxt = '0;
        end else if (w_inc && (r_veh != VEH_CNT_MAX)) begin
            w_veh_nxt = r_veh + 8'd1;
        end else begin
            w_veh_nxt = r_veh;
        end

        w_car_nxt = is_present(w_state_nxt);
    end

    assign o_car     = r_car;
    assign o_veh_cnt = r_veh;
    assign o_fault   = r_fault;

endmodule

// File: rtl/car_sensor_cond.sv
// Vehicle-detector conditioner: two independent lanes sharing clock, reset and clears.
module car_sensor_cond #(
    parameter int unsigned DEB_CYC   = 4,
    parameter int unsigned HOLD_CYC  = 8,
    parameter int unsigned STUCK_CYC = 1000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       raw_a,
    input  logic       raw_b,
    input  logic       cnt_clr,
    input  logic       fault_clr,
    output logic       carA,
    output logic       carB,
    output logic [7:0] veh_cnt_a,
    output logic [7:0] veh_cnt_b,
    output logic       fault_a,
    output logic       fault_b
);

    sensor_lane #(
        .DEB_CYC   (DEB_CYC),
        .HOLD_CYC  (HOLD_CYC),
        .STUCK_CYC (STUCK_CYC),
        .CNT_W     (CNT_W)
    ) u_lane_a (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_raw       (raw_a),
        .i_cnt_clr   (cnt_clr),
        .i_fault_clr (fault_clr),
        .o_car       (carA),
        .o_veh_cnt   (veh_cnt_a),
        .o_fault     (fault_a)
    );

    sensor_lane #(
        .DEB_CYC   (DEB_CYC),
        .HOLD_CYC  (HOLD_CYC),
        .STUCK_CYC (STUCK_CYC),
        .CNT_W     (CNT_W)
    ) u_lane_b (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_raw       (raw_b),
        .i_cnt_clr   (cnt_clr),
        .i_fault_clr (fault_clr),
        .o_car       (carB),
        .o_veh_cnt   (veh_cnt_b),
        .o_fault     (fault_b)
    );

endmodule

// File: tb/tb_car_sensor_cond.sv
// Directed bench for car_sensor_cond at default parameters.
module tb_car_sensor_cond;

    logic       clk = 1'b0;
    logic       rst;
    logic       raw_a;
    logic       raw_b;
    logic       cnt_clr;
    logic       fault_clr;
    logic       carA;
    logic       carB;
    logic [7:0] veh_cnt_a;
    logic [7:0] veh_cnt_b;
    logic       fault_a;
    logic       fault_b;

    int n_checks = 0;
    int n_errors = 0;

    car_sensor_cond dut (
        .clk       (clk),
        .rst       (rst),
        .raw_a     (raw_a),
        .raw_b     (raw_b),
        .cnt_clr   (cnt_clr),
        .fault_clr (fault_clr),
        .carA      (carA),
        .carB      (carB),
        .veh_cnt_a (veh_cnt_a),
        .veh_cnt_b (veh_cnt_b),
        .fault_a   (fault_a),
        .fault_b   (fault_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic ra;
        logic rb;
        int   n;
        logic ca;
        logic cb;
        int   va;
        int   vb;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance n active edges, then settle 1 time unit past the last edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // {raw_a, raw_b, edges, carA, carB, veh_a, veh_b} applied from idle after reset
        tbl[0]  = '{1'b1, 1'b0,  5, 1'b0, 1'b0, 0, 0};
        tbl[1]  = '{1'b1, 1'b0,  1, 1'b1, 1'b0, 1, 0};
        tbl[2]  = '{1'b1, 1'b0, 14, 1'b1, 1'b0, 1, 0};
        tbl[3]  = '{1'b0, 1'b0,  9, 1'b1, 1'b0, 1, 0};
        tbl[4]  = '{1'b0, 1'b0,  1, 1'b0, 1'b0, 1, 0};
        tbl[5]  = '{1'b0, 1'b1,  1, 1'b0, 1'b0, 1, 0};
        tbl[6]  = '{1'b0, 1'b0, 10, 1'b0, 1'b0, 1, 0};
        tbl[7]  = '{1'b0, 1'b1,  2, 1'b0, 1'b0, 1, 0};
        tbl[8]  = '{1'b0, 1'b0, 10, 1'b0, 1'b0, 1, 0};
        tbl[9]  = '{1'b0, 1'b1,  3, 1'b0, 1'b0, 1, 0};
        tbl[10] = '{1'b0, 1'b0, 10, 1'b0, 1'b0, 1, 0};
        tbl[11] = '{1'b0, 1'b1,  4, 1'b0, 1'b0, 1, 0};
        tbl[12] = '{1'b0, 1'b0,  2, 1'b0, 1'b1, 1, 1};
        tbl[13] = '{1'b0, 1'b0,  7, 1'b0, 1'b1, 1, 1};
        tbl[14] = '{1'b0, 1'b0,  1, 1'b0, 1'b0, 1, 1};

        rst = 1'b1; raw_a = 1'b0; raw_b = 1'b0; cnt_clr = 1'b0; fault_clr = 1'b0;
        tick(2);
        chk("rst_carA", 32'(carA), 0);
        chk("rst_carB", 32'(carB), 0);
        chk("rst_veh_a", 32'(veh_cnt_a), 0);
        chk("rst_veh_b", 32'(veh_cnt_b), 0);
        chk("rst_fault_a", 32'(fault_a), 0);
        chk("rst_fault_b", 32'(fault_b), 0);
        rst = 1'b0;

        // Asynchronous reset in mid-presence
        raw_a = 1'b1; raw_b = 1'b1;
        tick(8);
        chk("pre_rst_carA", 32'(carA), 1);
        chk("pre_rst_carB", 32'(carB), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_carA", 32'(carA), 0);
        chk("async_rst_carB", 32'(carB), 0);
        chk("async_rst_veh_a", 32'(veh_cnt_a), 0);
        chk("async_rst_veh_b", 32'(veh_cnt_b), 0);
        #1 rst = 1'b0;
        tick(5);
        chk("post_rst_e5_carA", 32'(carA), 0);
        tick(1);
        chk("post_rst_e6_carA", 32'(carA), 1);
        chk("post_rst_e6_veh_a", 32'(veh_cnt_a), 1);
        raw_a = 1'b0; raw_b = 1'b0; rst = 1'b1;
        tick(1);
        rst = 1'b0;

        // Arrival/departure latency, glitches and the shortest accepted pulse
        for (int i = 0; i < 15; i++) begin
            raw_a = tbl[i].ra;
            raw_b = tbl[i].rb;
            tick(tbl[i].n);
            chk($sformatf("vec%0d_carA", i), 32'(carA), 32'(tbl[i].ca));
            chk($sformatf("vec%0d_carB", i), 32'(carB), 32'(tbl[i].cb));
            chk($sformatf("vec%0d_veh_a", i), 32'(veh_cnt_a), 32'(tbl[i].va));
            chk($sformatf("vec%0d_veh_b", i), 32'(veh_cnt_b), 32'(tbl[i].vb));
        end

        // Gap extension: a 5-cycle gap is the same vehicle
        raw_a = 1'b1;
        tick(6);
        chk("gap_arrive_carA", 32'(carA), 1);
        chk("gap_arrive_veh_a", 32'(veh_cnt_a), 2);
        raw_a = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk($sformatf("gap_low%0d_carA", i), 32'(carA), 1);
        end
        raw_a = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk($sformatf("gap_high%0d_carA", i), 32'(carA), 1);
        end
        chk("gap_veh_a", 32'(veh_cnt_a), 2);
        raw_a = 1'b0;
        tick(9);
        chk("gap_depart_e9_carA", 32'(carA), 1);
        tick(1);
        chk("gap_depart_e10_carA", 32'(carA), 0);
        tick(2);
        chk("gap_depart_e12_carA", 32'(carA), 0);

        // Stuck detector on lane B
        raw_b = 1'b1;
        tick(1005);
        chk("stuck_e1005_fault_b", 32'(fault_b), 0);
        chk("stuck_e1005_carB", 32'(carB), 1);
        chk("stuck_veh_b", 32'(veh_cnt_b), 2);
        tick(1);
        chk("stuck_e1006_fault_b", 32'(fault_b), 1);
        chk("stuck_e1006_fault_a", 32'(fault_a), 0);
        tick(93);
        chk("stuck_sticky_fault_b", 32'(fault_b), 1);
        chk("stuck_faulted_carB", 32'(carB), 1);
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        chk("fclr_e1100_fault_b", 32'(fault_b), 0);
        tick(999);
        chk("fclr_e2099_fault_b", 32'(fault_b), 0);
        tick(1);
        chk("fclr_e2100_fault_b", 32'(fault_b), 1);
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        chk("fclr_e2101_fault_b", 32'(fault_b), 0);
        tick(999);
        chk("fclr_e3100_fault_b", 32'(fault_b), 0);
        fault_clr = 1'b1;
        tick(1);
        fault_clr = 1'b0;
        chk("fclr_on_set_edge_fault_b", 32'(fault_b), 0);
        tick(1);
        chk("fclr_after_set_edge_fault_b", 32'(fault_b), 0);
        chk("fclr_carB", 32'(carB), 1);
        raw_b = 1'b0;
        tick(12);
        chk("stuck_release_carB", 32'(carB), 0);

        // Counter clear, saturation and clear-versus-increment
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        chk("cclr_veh_a", 32'(veh_cnt_a), 0);
        chk("cclr_veh_b", 32'(veh_cnt_b), 0);
        for (int i = 0; i < 260; i++) begin
            raw_a = 1'b1;
            tick(6);
            raw_a = 1'b0;
            tick(12);
            if (i == 0)   chk("sat_arr1_veh_a", 32'(veh_cnt_a), 1);
            if (i == 253) chk("sat_arr254_veh_a", 32'(veh_cnt_a), 254);
            if (i == 254) chk("sat_arr255_veh_a", 32'(veh_cnt_a), 255);
        end
        chk("sat_arr260_veh_a", 32'(veh_cnt_a), 255);
        chk("sat_veh_b", 32'(veh_cnt_b), 0);
        raw_a = 1'b1;
        tick(5);
        cnt_clr = 1'b1;
        tick(1);
        cnt_clr = 1'b0;
        chk("cclr_vs_inc_carA", 32'(carA), 1);
        chk("cclr_vs_inc_veh_a", 32'(veh_cnt_a), 0);
        raw_a = 1'b0;
        tick(12);
        raw_a = 1'b1;
        tick(6);
        chk("after_cclr_veh_a", 32'(veh_cnt_a), 1);
        raw_a = 1'b0;
        tick(12);
        chk("final_carA", 32'(carA), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
